// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and baud-timed shifter
// Optional parity bit after the data bits is built when UART_TX_PARITY_EN is defined.
module mmio_uart_tx #(
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [15:0] DIVISOR_RESET = 16'd217
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sel,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_width,
  input  logic        i_we,
  input  logic        i_zeroextend,
  output logic [31:0] o_rdata,
  output logic        o_tx,
  output logic        o_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] divisor_q, divisor_d;
  logic        tx_en_q, tx_en_d;
  logic        irq_en_q, irq_en_d;
  logic        overflow_q, overflow_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic        parity_odd_q, parity_odd_d;
  logic        parity_q, parity_d;
`endif

  logic        fifo_full, fifo_empty, busy, push_req, push, pop;
  logic        aligned, do_store, is_load;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data, bit_mask, rd_word, rd_shift, load_val;
  logic [15:0] div_m1;
  logic        ctrl_parity_rd;
  logic        unused_ok;

  assign unused_ok  = ^i_addr[31:4];
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign busy       = (state_q != ST_IDLE);
  assign div_m1     = (divisor_q == 16'd0) ? 16'd0 : divisor_q - 16'd1;
`ifdef UART_TX_PARITY_EN
  assign ctrl_parity_rd = parity_odd_q;
`else
  assign ctrl_parity_rd = 1'b0;
`endif

  // Bus decode: lane placement of store data and alignment of the access.
  always_comb begin
    wr_data = '0;
    wr_mask = '0;
    aligned = 1'b1;
    case (i_width)
      2'd1: begin
        wr_data = {4{i_wdata[7:0]}};
        wr_mask = 4'b0001 << i_addr[1:0];
      end
      2'd2: begin
        wr_data = {2{i_wdata[15:0]}};
        wr_mask = i_addr[1] ? 4'b1100 : 4'b0011;
        aligned = ~i_addr[0];
      end
      2'd3: begin
        wr_data = i_wdata;
        wr_mask = 4'hF;
        aligned = (i_addr[1:0] == 2'd0);
      end
      default: ;
    endcase
    bit_mask = {{8{wr_mask[3]}}, {8{wr_mask[2]}}, {8{wr_mask[1]}}, {8{wr_mask[0]}}};
    do_store = i_sel & i_we & (i_width != 2'd0) & aligned;
    is_load  = i_sel & ~i_we & (i_width != 2'd0);
    push_req = do_store & (i_addr[3:2] == 2'd0) & wr_mask[0];
    push     = push_req & ~fifo_full;
  end

  always_comb begin
    case (i_addr[3:2])
      2'd1:    rd_word = {19'd0, 5'(count_q), 4'd0, overflow_q, busy, fifo_empty, fifo_full};
      2'd2:    rd_word = {16'd0, divisor_q};
      2'd3:    rd_word = {29'd0, irq_en_q, ctrl_parity_rd, tx_en_q};
      default: rd_word = 32'd0;
    endcase
    rd_shift = rd_word >> {i_addr[1:0], 3'b000};
    load_val = 32'd0;
    if (aligned) begin
      case (i_width)
        2'd1:    load_val = i_zeroextend ? {24'd0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
        2'd2:    load_val = i_zeroextend ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
        default: load_val = rd_shift;
      endcase
    end
    rdata_d = is_load ? load_val : rdata_q;
  end

  // Register file writes; overflow is sticky until software writes 1 to STATUS[3].
  always_comb begin
    divisor_d  = divisor_q;
    tx_en_d    = tx_en_q;
    irq_en_d   = irq_en_q;
    overflow_d = overflow_q;
`ifdef UART_TX_PARITY_EN
    parity_odd_d = parity_odd_q;
`endif
    if (do_store) begin
      case (i_addr[3:2])
        2'd1: if (wr_mask[0] && wr_data[3]) overflow_d = 1'b0;
        2'd2: divisor_d = (divisor_q & ~bit_mask[15:0]) | (wr_data[15:0] & bit_mask[15:0]);
        2'd3: if (wr_mask[0]) begin
          tx_en_d  = wr_data[0];
          irq_en_d = wr_data[2];
`ifdef UART_TX_PARITY_EN
          parity_odd_d = wr_data[1];
`endif
        end
        default: ;
      endcase
    end
    if (push_req && fifo_full) overflow_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // TX FSM: each bit holds baud_q from reload down to 0; STOP may chain directly into START.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (state_q != ST_IDLE && baud_q != 16'd0) begin
      baud_d = baud_q - 16'd1;
    end else begin
      case (state_q)
        ST_START: begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          baud_d    = div_m1;
        end
        ST_DATA: begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          baud_d    = div_m1;
`ifdef UART_TX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = ST_PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
`endif
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          state_d = ST_STOP;
          baud_d  = div_m1;
        end
`endif
        default: begin
          state_d = ST_IDLE;
          if (tx_en_q && !fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            state_d = ST_START;
            baud_d  = div_m1;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_mem[rd_ptr_q] ^ parity_odd_q;
`endif
          end
        end
      endcase
    end
  end

  always_comb begin
    case (state_q)
      ST_START: o_tx = 1'b0;
      ST_DATA:  o_tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: o_tx = parity_q;
`endif
      default:  o_tx = 1'b1;
    endcase
  end

  assign o_irq   = irq_en_q & fifo_empty & ~busy;
  assign o_rdata = rdata_q;

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wr_data[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      divisor_q  <= DIVISOR_RESET;
      tx_en_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rdata_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_odd_q <= 1'b0;
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      divisor_q  <= divisor_d;
      tx_en_q    <= tx_en_d;
      irq_en_q   <= irq_en_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
`ifdef UART_TX_PARITY_EN
      parity_odd_q <= parity_odd_d;
      parity_q     <= parity_d;
`endif
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
// Frame expectations follow UART_TX_PARITY_EN when the bench is built with it.
module tb_mmio_uart_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  width = '0;
  logic        we = 1'b0;
  logic        zext = 1'b0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] rd;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam logic [31:0] CTRL7_RD = 32'h7;
`else
  localparam int NBITS = 10;
  localparam logic [31:0] CTRL7_RD = 32'h5;
`endif

  mmio_uart_tx dut (
    .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_addr(addr), .i_wdata(wdata),
    .i_width(width), .i_we(we), .i_zeroextend(zext),
    .o_rdata(rdata), .o_tx(tx), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d; width = w;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; width = 2'd0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] w, input logic z, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a; width = w; zext = z;
    @(negedge clk);
    d = rdata;
    sel = 1'b0; width = 2'd0;
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int idx, input logic odd);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^d ^ odd;
`endif
    return 1'b1;
  endfunction

  // Divisor must be 4 here: every line bit is expected to last four clocks.
  task automatic send_frame(input logic [7:0] d, input logic odd, input logic irq_after);
    logic found;
    found = 1'b0;
    store(32'h0, {24'd0, d}, 2'd1);
    check("irq_low_on_push", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("start_bit_seen", {31'd0, found}, 32'd1);
    for (int k = 0; k < NBITS * 4; k++) begin
      check($sformatf("tx_bit%0d_clk%0d", k / 4, k % 4), {31'd0, tx}, {31'd0, frame_bit(d, k / 4, odd)});
      if (k == NBITS * 4 - 1) check("irq_low_in_stop", {31'd0, irq}, 32'd0);
      @(negedge clk);
    end
    check("irq_after_stop", {31'd0, irq}, {31'd0, irq_after});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    load(32'h4, 2'd3, 1'b1, rd); check("rst_status", rd, 32'h2);
    load(32'h8, 2'd3, 1'b1, rd); check("rst_divisor", rd, 32'd217);
    load(32'hC, 2'd3, 1'b1, rd); check("rst_ctrl", rd, 32'h0);

    store(32'h8, 32'd4, 2'd3);
    store(32'hC, 32'd1, 2'd3);
    send_frame(8'h55, 1'b0, 1'b0);
    load(32'h4, 2'd3, 1'b1, rd); check("status_after_frame", rd, 32'h2);

    store(32'hC, 32'd5, 2'd3);
    @(negedge clk);
    check("irq_idle_empty", {31'd0, irq}, 32'd1);
    store(32'hC, 32'd7, 2'd3);
    load(32'hC, 2'd3, 1'b1, rd); check("ctrl_readback", rd, CTRL7_RD);
    send_frame(8'h07, 1'b1, 1'b1);
    store(32'hC, 32'd5, 2'd3);
    send_frame(8'h07, 1'b0, 1'b1);

    store(32'h8, 32'h1234, 2'd3);
    load(32'h9, 2'd1, 1'b1, rd); check("lbu_0x9", rd, 32'h12);
    load(32'h8, 2'd1, 1'b0, rd); check("lb_0x8", rd, 32'h34);
    load(32'h8, 2'd2, 1'b0, rd); check("lh_0x8", rd, 32'h1234);
    store(32'h8, 32'h8080, 2'd2);
    load(32'h8, 2'd2, 1'b0, rd); check("lh_0x8_neg", rd, 32'hFFFF8080);
    load(32'h8, 2'd2, 1'b1, rd); check("lhu_0x8", rd, 32'h00008080);
    load(32'h9, 2'd1, 1'b0, rd); check("lb_0x9_neg", rd, 32'hFFFFFF80);
    load(32'h9, 2'd2, 1'b1, rd); check("lh_misaligned", rd, 32'h0);
    load(32'h0, 2'd3, 1'b1, rd); check("txdata_read", rd, 32'h0);

    store(32'h8, 32'h1234, 2'd3);
    store(32'h9, 32'hBEEF, 2'd2);
    load(32'h8, 2'd3, 1'b1, rd); check("sh_misaligned_ignored", rd, 32'h1234);
    store(32'h9, 32'hAA, 2'd1);
    load(32'h8, 2'd3, 1'b1, rd); check("sb_lane1", rd, 32'hAA34);

    store(32'hC, 32'd0, 2'd3);
    for (int i = 0; i < 17; i++) store(32'h0, 32'(i), 2'd1);
    load(32'h4, 2'd3, 1'b1, rd); check("status_full_ovf", rd, 32'h1009);
    load(32'h5, 2'd1, 1'b1, rd); check("count_byte", rd, 32'h10);
    store(32'h4, 32'h8, 2'd3);
    load(32'h4, 2'd3, 1'b1, rd); check("status_ovf_cleared", rd, 32'h1001);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst2_rdata", rdata, 32'd0);
    store(32'h8, 32'd2, 2'd3);
    store(32'hC, 32'd1, 2'd3);
    store(32'h0, 32'h01, 2'd1);
    store(32'h0, 32'h02, 2'd1);
    store(32'h0, 32'h03, 2'd1);
    repeat (24) @(negedge clk);
    load(32'h4, 2'd3, 1'b1, rd); check("status_mid_frame", rd, 32'h104);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst3_tx", {31'd0, tx}, 32'd1);
    check("rst3_irq", {31'd0, irq}, 32'd0);
    check("rst3_rdata", rdata, 32'd0);
    load(32'h4, 2'd3, 1'b1, rd); check("rst3_status", rd, 32'h2);
    load(32'h8, 2'd3, 1'b1, rd); check("rst3_divisor", rd, 32'd217);
    load(32'hC, 2'd3, 1'b1, rd); check("rst3_ctrl", rd, 32'h0);
    repeat (5) @(negedge clk);
    check("rst3_tx_stays_idle", {31'd0, tx}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
